// File: rtl/dmx_buffer_arbiter.sv
// ============================================================================
// dmx_buffer_arbiter - round-robin share of the DMX receive buffer read port
// Rev 1.0
// ============================================================================
`default_nettype none

module dmx_buffer_arbiter #(
  parameter int N_REQ  = 10,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        tx_en_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        req_sel_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [ADDR_W:0]         n_bytes_a_i,
  input  logic [ADDR_W:0]         n_bytes_b_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic                    rd_en_o,
  output logic                    rd_src_o,
  output logic [ADDR_W-1:0]       rd_addr_o,
  input  logic [DATA_W-1:0]       rd_data_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]       rsp_data_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0]   N_REQ_EXT = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              rd_en_q, rd_en_d;
  logic              oor_q, oor_d;
  logic              rd_src_q, rd_src_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [N_REQ-1:0]  s1_vld_q;
  logic              s1_oor_q;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [N_REQ-1:0]  clr_q;

  logic [N_REQ-1:0]  w_eligible;
  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic              w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic              w_in_range;

  assign w_eligible = req_i & tx_en_i & ~pending_q;

  // Rotating priority search starting at ptr_q, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      logic [IDX_W:0] sum;
      sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (sum >= N_REQ_EXT) sum = sum - N_REQ_EXT;
      if (!w_found && w_eligible[sum[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_d  = '0;
    w_sel  = 1'b0;
    w_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_found && (w_win == IDX_W'(i))) begin
        gnt_d[i] = 1'b1;
        w_sel    = req_sel_i[i];
        w_addr   = req_addr_i[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    w_in_range = w_sel ? ({1'b0, w_addr} < n_bytes_b_i)
                       : ({1'b0, w_addr} < n_bytes_a_i);
    rd_en_d    = w_found & w_in_range;
    oor_d      = w_found & ~w_in_range;
    rd_src_d   = w_found ? w_sel  : rd_src_q;
    rd_addr_d  = w_found ? w_addr : rd_addr_q;
    ptr_d      = ptr_q;
    if (w_found) ptr_d = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
    // Pending drops one cycle after the response so the requester can retarget.
    pending_d  = (pending_q & ~clr_q) | gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      pending_q   <= '0;
      gnt_q       <= '0;
      rd_en_q     <= 1'b0;
      oor_q       <= 1'b0;
      rd_src_q    <= 1'b0;
      rd_addr_q   <= '0;
      s1_vld_q    <= '0;
      s1_oor_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      clr_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      pending_q   <= pending_d;
      gnt_q       <= gnt_d;
      rd_en_q     <= rd_en_d;
      oor_q       <= oor_d;
      rd_src_q    <= rd_src_d;
      rd_addr_q   <= rd_addr_d;
      s1_vld_q    <= gnt_q;
      s1_oor_q    <= oor_q;
      rsp_valid_q <= s1_vld_q;
      if (|s1_vld_q) rsp_data_q <= s1_oor_q ? '0 : rd_data_i;
      clr_q       <= rsp_valid_q;
    end
  end

  assign gnt_o       = gnt_q;
  assign rd_en_o     = rd_en_q;
  assign rd_src_o    = rd_src_q;
  assign rd_addr_o   = rd_addr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dmx_buffer_arbiter.sv
// ============================================================================
// tb_dmx_buffer_arbiter - directed vectors plus randomized scoreboard bench
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmx_buffer_arbiter;
  localparam int N_REQ  = 10;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        tx_en, req, req_sel, gnt, rsp_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [ADDR_W:0]         n_bytes_a, n_bytes_b;
  logic                    rd_en, rd_src;
  logic [ADDR_W-1:0]       rd_addr;
  logic [DATA_W-1:0]       rd_data = '0;
  logic [DATA_W-1:0]       rsp_data;

  dmx_buffer_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .tx_en_i(tx_en), .req_i(req), .req_sel_i(req_sel),
    .req_addr_i(req_addr), .n_bytes_a_i(n_bytes_a), .n_bytes_b_i(n_bytes_b),
    .gnt_o(gnt), .rd_en_o(rd_en), .rd_src_o(rd_src), .rd_addr_o(rd_addr),
    .rd_data_i(rd_data), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data)
  );

  always #5 clk = ~clk;

  // Receive buffers: registered read, data valid the cycle after rd_en.
  logic [7:0] mem_a [512];
  logic [7:0] mem_b [512];
  always @(posedge clk) if (rd_en) rd_data <= rd_src ? mem_b[rd_addr] : mem_a[rd_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of the arbiter.
  typedef struct { int due; int ch; logic [7:0] data; } rsp_t;
  rsp_t             rq[$];
  int               m_ptr, edge_n;
  int               m_busy [N_REQ];
  logic [N_REQ-1:0] e_gnt, e_rsp_valid;
  logic             e_rd_en, e_rd_src, chk_addr, chk_data;
  logic [8:0]       e_rd_addr;
  logic [7:0]       e_rsp_data;

  task automatic model_edge();
    int win, c, addr, lim;
    bit sel;
    edge_n++;
    e_gnt = '0; e_rd_en = 1'b0; e_rsp_valid = '0; chk_addr = 1'b0; chk_data = 1'b0;
    if (rst) begin
      m_ptr = 0; rq.delete();
      for (int i = 0; i < N_REQ; i++) m_busy[i] = 0;
      e_rd_src = 1'b0; e_rd_addr = '0; e_rsp_data = '0; chk_addr = 1'b1; chk_data = 1'b1;
      return;
    end
    if (rq.size() > 0 && rq[0].due == edge_n) begin
      e_rsp_valid[rq[0].ch] = 1'b1; e_rsp_data = rq[0].data; chk_data = 1'b1;
      void'(rq.pop_front());
    end
    win = -1;
    for (int k = 0; k < N_REQ; k++) begin
      c = (m_ptr + k) % N_REQ;
      if (win < 0 && req[c] && tx_en[c] && m_busy[c] == 0) win = c;
    end
    for (int i = 0; i < N_REQ; i++) if (m_busy[i] > 0) m_busy[i]--;
    if (win >= 0) begin
      sel  = req_sel[win];
      addr = int'(req_addr[win*ADDR_W +: ADDR_W]);
      lim  = sel ? int'(n_bytes_b) : int'(n_bytes_a);
      e_gnt[win] = 1'b1; e_rd_en = (addr < lim); e_rd_src = sel;
      e_rd_addr = 9'(addr); chk_addr = 1'b1;
      rq.push_back('{edge_n + 2, win, (addr < lim) ? (sel ? mem_b[addr] : mem_a[addr]) : 8'h00});
      // Locked out for the four sampling edges up to the pending clear.
      m_busy[win] = 4;
      m_ptr = (win + 1) % N_REQ;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("m_gnt", 32'(gnt), 32'(e_gnt));
    check("m_rd_en", 32'(rd_en), 32'(e_rd_en));
    check("m_rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
    if (chk_addr) begin
      check("m_rd_src", 32'(rd_src), 32'(e_rd_src));
      check("m_rd_addr", 32'(rd_addr), 32'(e_rd_addr));
    end
    if (chk_data) check("m_rsp_data", 32'(rsp_data), 32'(e_rsp_data));
  endtask

  task automatic set_ch(input int ch, input bit sel, input int addr);
    req_sel[ch] = sel;
    req_addr[ch*ADDR_W +: ADDR_W] = 9'(addr);
  endtask

  typedef struct { int ch; bit sel; int addr; int nb_a; int nb_b; bit rd_en; logic [7:0] data; } vec_t;
  vec_t vecs [10];

  initial begin
    logic [N_REQ-1:0] eg;
    int tmp;
    bit got;
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = 8'(i) ^ 8'hA5;
      mem_b[i] = ~8'(i);
    end
    mem_a[5] = 8'h7E;
    vecs[0] = '{3, 1'b0,   5, 512, 512, 1'b1, 8'h7E};
    vecs[1] = '{1, 1'b1, 100, 512, 100, 1'b0, 8'h00};
    vecs[2] = '{0, 1'b0,   0, 512, 512, 1'b1, 8'hA5};
    vecs[3] = '{9, 1'b0, 511, 512, 512, 1'b1, 8'h5A};
    vecs[4] = '{6, 1'b1,  99,   0, 100, 1'b1, 8'h9C};
    vecs[5] = '{7, 1'b1,   0, 512,   0, 1'b0, 8'h00};
    vecs[6] = '{5, 1'b0, 300, 301,   0, 1'b1, 8'h89};
    vecs[7] = '{8, 1'b0, 301, 301, 512, 1'b0, 8'h00};
    vecs[8] = '{2, 1'b1,  18,   0,  19, 1'b1, 8'hED};
    vecs[9] = '{4, 1'b0, 511, 511,   0, 1'b0, 8'h00};

    rst = 1'b1; tx_en = '1; req = '0; req_sel = '0; req_addr = '0;
    n_bytes_a = 10'd512; n_bytes_b = 10'd512;
    m_ptr = 0; edge_n = 0;
    for (int i = 0; i < N_REQ; i++) m_busy[i] = 0;
    step(); step();
    check("reset_gnt", 32'(gnt), 0);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_data", 32'(rsp_data), 0);
    rst = 1'b0;
    step();

    // Single-request vectors.
    foreach (vecs[v]) begin
      eg = '0; eg[vecs[v].ch] = 1'b1;
      n_bytes_a = 10'(vecs[v].nb_a); n_bytes_b = 10'(vecs[v].nb_b);
      set_ch(vecs[v].ch, vecs[v].sel, vecs[v].addr);
      req = eg;
      step();
      check("vec_gnt", 32'(gnt), 32'(eg));
      check("vec_rd_en", 32'(rd_en), 32'(vecs[v].rd_en));
      check("vec_rd_src", 32'(rd_src), 32'(vecs[v].sel));
      check("vec_rd_addr", 32'(rd_addr), 32'(vecs[v].addr));
      req = '0;
      step(); step();
      check("vec_rsp_valid", 32'(rsp_valid), 32'(eg));
      check("vec_rsp_data", 32'(rsp_data), 32'(vecs[v].data));
      step(); step(); step();
    end

    // Held request on ch3: re-grant exactly five cycles after the first grant.
    n_bytes_a = 10'd512; set_ch(3, 1'b0, 5); req = 10'b0000001000;
    step();
    check("ch3_gnt", 32'(gnt[3]), 1);
    check("ch3_rd_en", 32'(rd_en), 1);
    check("ch3_rd_addr", 32'(rd_addr), 5);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("ch3_regrant", 32'(gnt[3]), (k == 5) ? 1 : 0);
      if (k == 2) begin
        check("ch3_rsp_valid", 32'(rsp_valid), 32'h8);
        check("ch3_rsp_data", 32'(rsp_data), 32'h7E);
      end
    end
    req = '0;
    step(); step(); step(); step(); step();

    // All channels from reset.
    rst = 1'b1; step(); rst = 1'b0;
    n_bytes_b = 10'd512;
    for (int i = 0; i < N_REQ; i++) set_ch(i, 1'(i % 2), 10 * i);
    req = '1;
    for (int k = 1; k <= 12; k++) begin
      step();
      eg = '0; if (k <= 10) eg[k-1] = 1'b1;
      check("all_gnt", 32'(gnt), 32'(eg));
      eg = '0; if (k >= 3) eg[k-3] = 1'b1;
      check("all_rsp", 32'(rsp_valid), 32'(eg));
      if (k == 10) req = '0;
    end
    for (int k = 0; k < 5; k++) step();

    // Pointer wrap: ch0 then ch9.
    req = 10'b1000000001;
    step(); check("wrap_first", 32'(gnt), 32'h001);
    step(); check("wrap_second", 32'(gnt), 32'h200);
    req = '0;
    for (int k = 0; k < 6; k++) step();

    // Disabled channel is never granted until enabled.
    tx_en = 10'b1111111011; req = 10'b0000000100; set_ch(2, 1'b0, 7);
    for (int k = 0; k < 50; k++) begin
      step(); check("mask_no_gnt", 32'(gnt), 0);
    end
    tx_en = '1; got = 1'b0;
    for (int k = 0; k < N_REQ && !got; k++) begin
      step(); if (gnt[2]) got = 1'b1;
    end
    check("mask_gnt_within_n", 32'(got), 1);
    req = '0;
    for (int k = 0; k < 6; k++) step();

    // Reset while ch4 is in flight.
    set_ch(4, 1'b0, 20); req = 10'b0000010000;
    step(); check("mid_gnt4", 32'(gnt), 32'h010);
    req = '0;
    step();
    rst = 1'b1;
    step();
    check("mid_rst_rsp", 32'(rsp_valid), 0);
    check("mid_rst_rd_en", 32'(rd_en), 0);
    check("mid_rst_rd_addr", 32'(rd_addr), 0);
    rst = 1'b0;
    req = 10'b0010010001; set_ch(0, 1'b0, 1); set_ch(7, 1'b1, 2);
    step(); check("post_rst_gnt0", 32'(gnt), 32'h001);
    check("post_rst_no_rsp_a", 32'(rsp_valid), 0);
    step(); check("post_rst_gnt4", 32'(gnt), 32'h010);
    check("post_rst_no_rsp_b", 32'(rsp_valid), 0);
    step(); check("post_rst_gnt7", 32'(gnt), 32'h080);
    req = '0;
    for (int k = 0; k < 6; k++) step();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) n_bytes_a = 10'($urandom_range(0, 512));
      if ($urandom_range(0, 15) == 0) n_bytes_b = 10'($urandom_range(0, 512));
      if ($urandom_range(0, 7) == 0) begin
        tmp = $urandom_range(0, N_REQ - 1);
        tx_en[tmp] = ~tx_en[tmp];
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && m_busy[i] == 0) begin
          if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
        end else begin
          req[i] = ($urandom_range(0, 2) != 0);
          set_ch(i, 1'($urandom_range(0, 1)), $urandom_range(0, 511));
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmx_buffer_arbiter.md
# dmx_buffer_arbiter

Round-robin arbiter that shares the single read port of the DMX receive buffer between the DMX output channels. Each output requests one slot byte at a time from input A or B. The arbiter issues at most one buffer read per cycle, range-checks the request against that input's current byte count, and returns the byte to the requester with a one-hot valid. It sits between the DMX input buffers and the DMX output modules. Per-channel enables come from the SPI register map.

## Interface

Parameters:
- N_REQ, 10, number of requesting output channels
- ADDR_W, 9, slot index width (512 slots)
- DATA_W, 8, slot byte width

Ports:
- clk  in  1  system clock (20 MHz PLL output)
- rst  in  1  synchronous, active-high reset
- tx_en  in  N_REQ  per-channel enable (SPI TX_EN bits); 0 = requester ineligible
- req  in  N_REQ  level request, one bit per channel
- req_sel  in  N_REQ  source select per channel: 0 = input A, 1 = input B
- req_addr  in  N_REQ*ADDR_W  slot index per channel; channel i at bits [i*ADDR_W +: ADDR_W]
- n_bytes_a  in  ADDR_W+1  valid byte count in buffer A
- n_bytes_b  in  ADDR_W+1  valid byte count in buffer B
- gnt  out  N_REQ  one-hot grant pulse, one cycle
- rd_en  out  1  buffer read strobe
- rd_src  out  1  buffer select for the read (copy of the winner's req_sel)
- rd_addr  out  ADDR_W  buffer read index
- rd_data  in  DATA_W  buffer data, valid in the cycle after rd_en
- rsp_valid  out  N_REQ  one-hot response pulse, one cycle
- rsp_data  out  DATA_W  response byte, qualified by rsp_valid

## Operation

- Eligible(i) = req[i] & tx_en[i] & ~pending[i].
- Arbitration:
  - Search starts at ptr and wraps modulo N_REQ.
  - The first eligible index wins.
  - After a grant, ptr = winner+1, with N_REQ-1 wrapping to 0.
  - With no eligible requester, ptr holds and no grant is issued.
- Grant (registered):
  - gnt[w]=1 for one cycle.
  - pending[w] is set.
  - rd_src and rd_addr load the winner's sel and addr.
- Range check at grant:
  - addr < n_bytes_a when sel=0; addr < n_bytes_b when sel=1.
  - In range: rd_en=1 in the gnt cycle.
  - Out of range: rd_en=0 in the gnt cycle, and the response byte is forced to 8'h00.
- Response:
  - The winner index and the out-of-range flag are pipelined alongside the read.
  - rsp_valid[w] and rsp_data are registered from rd_data, or 8'h00 when out of range.
- pending[w] clears on the clock edge that ends the cycle after rsp_valid[w]. The requester therefore has one full cycle after rsp_valid to update req_addr/req_sel or drop req before it is sampled again.
- Requester rule: req_sel and req_addr must be stable from req assertion until gnt.
- tx_en falling while pending[i]=1 does not cancel the transaction; the response is still delivered.
- n_bytes changes are sampled only at grant; in-flight reads are unaffected.

## Timing

- Reset values:
  - gnt, rd_en, rsp_valid, pending: 0.
  - rd_src: 0; rd_addr: 0; rsp_data: 8'h00.
  - ptr: 0.
- Cycle sequence:
  - Edge E0: request sampled.
  - Cycle after E0: gnt and rd_en/rd_addr asserted.
  - Next cycle: rd_data valid.
  - Following cycle: rsp_valid. Latency is 3 cycles from the sampling edge.
- Throughput:
  - Aggregate: one grant per cycle.
  - Per channel: one byte per 5 cycles.
- Outputs: gnt, rsp_valid and rd_en are each at most one-hot or single-bit per cycle. A new grant and a response to a different channel may coincide.
- Reset mid-operation: all in-flight transactions are dropped, no rsp_valid is emitted afterwards, and the first grant after reset searches from index 0.

## Test plan

- Single requester: ch3 requests A addr 5, n_bytes_a=512, buffer A[5]=8'h7E.
  - gnt[3] 1 cycle after sampling, with rd_en=1, rd_src=0, rd_addr=5.
  - rsp_valid[3] with rsp_data=8'h7E 2 cycles later.
  - ch3 is not re-granted before the cycle after rsp_valid.
- All 10 channels request from reset: grants on ch0..ch9 in 10 consecutive cycles. Responses arrive in the same order, each 2 cycles after its grant.
- Wrap-around: after ch9 is granted, ch0 and ch9 request together (ch9 no longer pending). ch0 is granted first, then ch9.
- Out of range: ch1 requests B addr 100 with n_bytes_b=100.
  - gnt[1]=1, rd_en=0.
  - rsp_valid[1] with rsp_data=8'h00.
- tx_en mask: ch2 req=1 with tx_en[2]=0 gets no grant for 50 cycles. Setting tx_en[2]=1 yields a grant within N_REQ cycles.
- Reset mid-flight: assert rst in the cycle after gnt[4].
  - No rsp_valid appears.
  - All outputs are 0 after rst.
  - The next grant, with ch0 and ch4 requesting, goes to ch0.
